// File: rtl/pipeline_debug_sequencer.sv
// Debug sequencer for a pipelined core: loads instruction memory over a byte link,
// runs or single-steps the pipeline, then reports the unhalted-cycle count back.
module pipeline_debug_sequencer #(
  parameter int NB_DATA      = 32,
  parameter int NB_BYTE      = 8,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic [NB_DATA-1:0] i_instr_IF,
  input  logic               i_tx_ready,
  output logic               o_we_IF,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic               o_halt,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic [NB_DATA-1:0] o_cycle_count,
  output logic [2:0]         o_state
);

  localparam int N_BYTES = NB_DATA / NB_BYTE;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int DRN_W   = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(N_BYTES - 1);
  localparam logic [DRN_W-1:0]   LAST_DRN  = DRN_W'(DRAIN_CYCLES - 1);
  localparam logic [NB_DATA-1:0] HALT_WORD = '1;
  localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'('h4C);
  localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'('h52);
  localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'('h53);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RUN    = 3'd2,
    DRAIN  = 3'd3,
    STEP   = 3'd4,
    REPORT = 3'd5
  } state_t;

  state_t                     state, state_nxt;
  logic [IDX_W-1:0]           rx_idx, tx_idx;
  logic [DRN_W-1:0]           drain_cnt;
  logic [NB_DATA-NB_BYTE-1:0] shift_q;
  logic [NB_DATA-1:0]         load_word, cycle_count;
  logic [NB_BYTE-1:0]         count_bytes [N_BYTES];
  logic                       word_done, tx_fire, running, load_cmd;

  // Bytes enter at the top and move down, so the first byte ends up in the LSBs.
  assign load_word = {i_rx_data, shift_q};
  assign word_done = (state == LOAD) && i_rx_valid && (rx_idx == LAST_IDX);
  assign load_cmd  = (state == IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);
  assign tx_fire   = (state == REPORT) && i_tx_ready;
  assign running   = (state == RUN) || (state == DRAIN) || (state == STEP);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: state_nxt = LOAD;
            CMD_RUN:  state_nxt = RUN;
            CMD_STEP: state_nxt = STEP;
            default:  state_nxt = IDLE;
          endcase
        end
      end
      LOAD:    if (word_done && (load_word == HALT_WORD)) state_nxt = IDLE;
      RUN:     if (i_instr_IF == HALT_WORD) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == LAST_DRN) state_nxt = REPORT;
      STEP:    state_nxt = REPORT;
      REPORT:  if (tx_fire && (tx_idx == LAST_IDX)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      rx_idx             <= '0;
      tx_idx             <= '0;
      drain_cnt          <= '0;
      shift_q            <= '0;
      cycle_count        <= '0;
      o_instruction_data <= '0;
      o_we_IF            <= 1'b0;
    end else begin
      o_we_IF <= 1'b0;

      if (load_cmd) begin
        rx_idx      <= '0;
        cycle_count <= '0;
      end else if (running) begin
        cycle_count <= cycle_count + NB_DATA'(1);
      end

      if ((state == LOAD) && i_rx_valid) begin
        shift_q <= load_word[NB_DATA-1:NB_BYTE];
        if (word_done) begin
          rx_idx             <= '0;
          o_instruction_data <= load_word;
          o_we_IF            <= 1'b1;
        end else begin
          rx_idx <= rx_idx + IDX_W'(1);
        end
      end

      if (state == DRAIN) drain_cnt <= drain_cnt + DRN_W'(1);
      else                drain_cnt <= '0;

      if (tx_fire) tx_idx <= (tx_idx == LAST_IDX) ? '0 : tx_idx + IDX_W'(1);
    end
  end

  // The count is frozen while reporting, so a plain byte mux keeps o_tx_data stable.
  always_comb begin
    for (int i = 0; i < N_BYTES; i++) count_bytes[i] = cycle_count[i*NB_BYTE +: NB_BYTE];
  end

  assign o_halt        = !running;
  assign o_tx_valid    = (state == REPORT);
  assign o_tx_data     = (state == REPORT) ? count_bytes[tx_idx] : '0;
  assign o_cycle_count = cycle_count;
  assign o_state       = state;

endmodule

// File: doc/pipeline_debug_sequencer.md
PIPELINE_DEBUG_SEQUENCER -- requirements
Module: pipeline_debug_sequencer

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 32, instruction and counter width.
REQ-002 The block SHALL have parameter NB_BYTE, default 8, command/data byte width.
REQ-003 The block SHALL have parameter DRAIN_CYCLES, default 4, cycles run after HALT is seen in IF.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port i_rst  input  1  reset, asynchronous and active-high.
REQ-006 The block SHALL have port i_rx_data  input  NB_BYTE  received byte from serial receiver.
REQ-007 The block SHALL have port i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
REQ-008 The block SHALL have port i_instr_IF  input  NB_DATA  instruction currently leaving IF stage.
REQ-009 The block SHALL have port i_tx_ready  input  1  transmitter accepts byte when high.
REQ-010 The block SHALL have port o_we_IF  output  1  instruction-memory write strobe to pipeline.
REQ-011 The block SHALL have port o_instruction_data  output  NB_DATA  word to write into instruction memory.
REQ-012 The block SHALL have port o_halt  output  1  freezes pipeline when high.
REQ-013 The block SHALL have port o_tx_data  output  NB_BYTE  byte to transmit.
REQ-014 The block SHALL have port o_tx_valid  output  1  o_tx_data valid; held until accepted.
REQ-015 The block SHALL have port o_cycle_count  output  NB_DATA  count of unhalted cycles.
REQ-016 The block SHALL have port o_state  output  3  current FSM state encoding.

Function
REQ-017 FSM states SHALL be IDLE=0, LOAD=1, RUN=2, DRAIN=3, STEP=4, REPORT=5.
REQ-018 In IDLE, rx byte 0x4C ('L') SHALL enter LOAD, clear byte index and o_cycle_count.
REQ-019 In IDLE, rx byte 0x52 ('R') SHALL enter RUN; 0x53 ('S') SHALL enter STEP; any other byte SHALL be ignored.
REQ-020 In LOAD, each rx byte SHALL be shifted in little-endian (first byte = bits 7:0); byte index wraps 3->0.
REQ-021 On the fourth byte, o_instruction_data SHALL update and o_we_IF SHALL pulse high for exactly one cycle, the cycle after the strobe.
REQ-022 If the completed word equals 0xFFFFFFFF (HALT), it SHALL still be written, then FSM SHALL return to IDLE.
REQ-023 o_halt SHALL be 0 only in RUN, DRAIN and the single STEP cycle; 1 in all other states.
REQ-024 o_cycle_count SHALL increment by 1 on every cycle with o_halt=0, wrapping 0xFFFFFFFF->0.
REQ-025 In RUN, when i_instr_IF equals 0xFFFFFFFF, FSM SHALL enter DRAIN next cycle.
REQ-026 DRAIN SHALL last exactly DRAIN_CYCLES cycles, then enter REPORT.
REQ-027 STEP SHALL last exactly one cycle, then enter REPORT.
REQ-028 REPORT SHALL send 4 bytes of o_cycle_count, LSB first, via o_tx_valid/i_tx_ready.
REQ-029 A byte transfers on a cycle with o_tx_valid=1 and i_tx_ready=1; o_tx_data SHALL be stable while waiting.
REQ-030 After the fourth byte transfers, o_tx_valid SHALL drop and FSM SHALL return to IDLE.
REQ-031 rx strobes in RUN, DRAIN, STEP and REPORT SHALL be ignored and SHALL not be buffered.
REQ-032 HALT seen in IF during STEP SHALL NOT trigger DRAIN; STEP goes to REPORT unconditionally.

Reset
REQ-033 Reset SHALL force IDLE from any state, mid-load or mid-report, discarding partial words and bytes.
REQ-034 Reset values SHALL be o_we_IF=0, o_instruction_data=0, o_halt=1, o_tx_data=0, o_tx_valid=0, o_cycle_count=0, o_state=0.
REQ-035 After reset release, no o_we_IF or o_tx_valid pulse SHALL occur without a fresh command.

Verification
REQ-036 Load: 'L', then 78 56 34 12, FF FF FF FF -> two o_we_IF pulses, data 0x12345678 then 0xFFFFFFFF, state IDLE.
REQ-037 Run: 'R', drive i_instr_IF=0xFFFFFFFF on the 10th RUN cycle -> o_halt low 10+4=14 cycles, tx bytes 0E 00 00 00.
REQ-038 Step: from count 14, 'S' -> o_halt low exactly 1 cycle, tx bytes 0F 00 00 00.
REQ-039 Backpressure: i_tx_ready low 5 cycles per byte -> o_tx_data stable and o_tx_valid held; all 4 bytes delivered in order.
REQ-040 Reset mid-operation: assert i_rst after 2 of 4 load bytes, then 'L' and 4 bytes AA BB CC DD -> single write of 0xDDCCBBAA.
REQ-041 Ignored input: byte 0x41 in IDLE and 'S' during RUN -> no state change, no extra o_we_IF or STEP.
